// File: rtl/onchip_ring_pkg.sv
// Shared encodings for the on-chip RAM ring-buffer master: command opcodes,
// FSM states and the full-word byte enable.
package onchip_ring_pkg;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [3:0] BYTE_ALL = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdIssue,
    StRdWait,
    StResp
  } state_e;

endpackage

// File: rtl/onchip_ring_if.sv
// Bundle of command/response/status handshakes and the Avalon-MM s1 drive.
// The master modport is the ring controller's view; slave is the environment's.
interface onchip_ring_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_empty;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              ovf_pulse;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, mem_readdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_empty, count, full, empty, ovf_pulse,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, mem_readdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_empty, count, full, empty, ovf_pulse,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_ring_ptrs.sv
// Head/tail/count registers of the ring with wrap at DEPTH-1 and full/empty decode.
module onchip_ring_ptrs #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_head_i,
  input  logic              inc_tail_i,
  input  logic              clear_i,
  output logic [ADDR_W-1:0] head_o,
  output logic [ADDR_W-1:0] tail_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CountMax = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] head_d, head_q, tail_d, tail_q;
  logic [ADDR_W:0]   count_d, count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (inc_head_i) head_d = (head_q == LastIdx) ? '0 : head_q + ADDR_W'(1);
      if (inc_tail_i) tail_d = (tail_q == LastIdx) ? '0 : tail_q + ADDR_W'(1);
      unique case ({inc_head_i, inc_tail_i})
        2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign full_o  = (count_q == CountMax);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/onchip_ring_master.sv
// Avalon-MM master running a word ring in single-port on-chip RAM.
// Define ONCHIP_RING_CLKGATE_EN to drop mem_clken outside RAM access states.
module onchip_ring_master
  import onchip_ring_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned BASE   = 0
) (
  input logic           clk,
  input logic           reset_n,
  onchip_ring_if.master bus
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE);

  state_e            state_d, state_q;
  logic              cmd_ready_d, cmd_ready_q;
  logic              rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_d, rsp_data_q;
  logic              rsp_empty_d, rsp_empty_q;
  logic              ovf_d, ovf_q;
  logic              cs_d, cs_q;
  logic              we_d, we_q;
  logic [3:0]        be_d, be_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;

  logic              accept, inc_head, inc_tail, clear;
  logic [ADDR_W-1:0] head, tail;
  logic [ADDR_W:0]   count;
  logic              full, empty;

  assign accept   = bus.cmd_valid & cmd_ready_q;
  assign clear    = accept & (bus.cmd_op == OP_CLEAR);
  assign inc_head = (state_q == StWr);
  // An empty-pop response never touched the RAM, so its accept leaves tail alone.
  assign inc_tail = (state_q == StResp) & bus.rsp_ready & ~rsp_empty_q;

  onchip_ring_ptrs #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ptrs (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .inc_head_i (inc_head),
    .inc_tail_i (inc_tail),
    .clear_i    (clear),
    .head_o     (head),
    .tail_o     (tail),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_empty_d = rsp_empty_q;
    ovf_d       = 1'b0;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    be_d        = '0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_PUSH: begin
              if (full) begin
                ovf_d = 1'b1;
              end else begin
                state_d     = StWr;
                cmd_ready_d = 1'b0;
                cs_d        = 1'b1;
                we_d        = 1'b1;
                be_d        = BYTE_ALL;
                addr_d      = BaseAddr + head;
                wdata_d     = bus.cmd_data;
              end
            end
            OP_POP: begin
              cmd_ready_d = 1'b0;
              if (empty) begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_empty_d = 1'b1;
              end else begin
                state_d = StRdIssue;
                cs_d    = 1'b1;
                be_d    = BYTE_ALL;
                addr_d  = BaseAddr + tail;
              end
            end
            default: ;
          endcase
        end
      end
      StWr: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
      end
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        // One-cycle RAM latency: readdata belongs to the address issued last cycle.
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus.mem_readdata;
        rsp_empty_d = 1'b0;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_empty_d = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_empty_q <= 1'b0;
      ovf_q       <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_empty_q <= rsp_empty_d;
      ovf_q       <= ovf_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef ONCHIP_RING_CLKGATE_EN
  logic clken_d, clken_q;
  assign clken_d = (state_d == StWr) | (state_d == StRdIssue) | (state_d == StRdWait);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clken_q <= 1'b0;
    else          clken_q <= clken_d;
  end
  assign bus.mem_clken = clken_q;
`else
  assign bus.mem_clken = 1'b1;
`endif

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_empty      = rsp_empty_q;
  assign bus.count          = count;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.ovf_pulse      = ovf_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_byteenable = be_q;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_write      = we_q;
  assign bus.mem_writedata  = wdata_q;

endmodule

// File: tb/tb_onchip_ring_master.sv
// Bench for onchip_ring_master (DEPTH=4, BASE=8): directed steps then random ops
// checked against a queue model of the ring and a behavioural 1-cycle RAM.
module tb_onchip_ring_master;
  import onchip_ring_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BASE   = 8;
`ifdef ONCHIP_RING_CLKGATE_EN
  localparam logic CLKEN_IDLE = 1'b0;
`else
  localparam logic CLKEN_IDLE = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  onchip_ring_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_ring_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BASE   (BASE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Single-port RAM with one-cycle read latency, gated by clken.
  logic [DATA_W-1:0] ram [0:1023];
  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
      else               bus.mem_readdata <= ram[bus.mem_address];
    end
  end

  int cs_cnt = 0;
  always @(posedge clk) if (bus.mem_chipselect) cs_cnt <= cs_cnt + 1;

  // Reference model: FIFO contents plus write/read slot indices modulo DEPTH.
  logic [31:0] m_q[$];
  int unsigned m_wp = 0;
  int unsigned m_rp = 0;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wp = 0;
    m_rp = 0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, bus.count, m_q.size());
    chk({tag, "_full"}, bus.full, m_q.size() == DEPTH);
    chk({tag, "_empty"}, bus.empty, m_q.size() == 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_empty", bus.rsp_empty, 0);
    chk("rst_ovf", bus.ovf_pulse, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_cs", bus.mem_chipselect, 0);
    chk("rst_we", bus.mem_write, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_be", bus.mem_byteenable, 0);
    chk("rst_wdata", bus.mem_writedata, 0);
    chk("rst_clken", bus.mem_clken, CLKEN_IDLE);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
  task automatic issue(input logic [1:0] op, input logic [31:0] data);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] d);
    bit was_full;
    was_full = (m_q.size() == DEPTH);
    issue(OP_PUSH, d);
    if (was_full) begin
      chk("ovf_pulse", bus.ovf_pulse, 1);
      chk("ovf_no_cs", bus.mem_chipselect, 0);
      chk("ovf_cmd_ready", bus.cmd_ready, 1);
      chk_status("ovf");
      @(negedge clk);
      chk("ovf_one_cycle", bus.ovf_pulse, 0);
    end else begin
      chk("wr_cs", bus.mem_chipselect, 1);
      chk("wr_we", bus.mem_write, 1);
      chk("wr_be", bus.mem_byteenable, 4'hF);
      chk("wr_addr", bus.mem_address, BASE + m_wp);
      chk("wr_data", bus.mem_writedata, d);
      chk("wr_clken", bus.mem_clken, 1);
      chk("wr_cmd_ready", bus.cmd_ready, 0);
      chk("wr_ovf", bus.ovf_pulse, 0);
      m_q.push_back(d);
      m_wp = (m_wp + 1) % DEPTH;
      @(negedge clk);
      chk("wr_done_ready", bus.cmd_ready, 1);
      chk("wr_done_cs", bus.mem_chipselect, 0);
      chk("wr_done_clken", bus.mem_clken, CLKEN_IDLE);
      chk_status("wr_done");
    end
  endtask

  task automatic do_pop(input int hold);
    bit          was_empty;
    logic [31:0] exp_d;
    int          c0;
    was_empty = (m_q.size() == 0);
    exp_d = was_empty ? 32'h0 : m_q[0];
    c0 = cs_cnt;
    bus.rsp_ready = 1'b0;
    issue(OP_POP, 32'h0);
    if (was_empty) begin
      chk("epop_valid", bus.rsp_valid, 1);
      chk("epop_empty_flag", bus.rsp_empty, 1);
      chk("epop_data", bus.rsp_data, 0);
      chk("epop_cs", bus.mem_chipselect, 0);
    end else begin
      chk("rd_cs", bus.mem_chipselect, 1);
      chk("rd_we", bus.mem_write, 0);
      chk("rd_addr", bus.mem_address, BASE + m_rp);
      chk("rd_clken", bus.mem_clken, 1);
      chk("rd_valid_early", bus.rsp_valid, 0);
      @(negedge clk);
      chk("rdw_cs", bus.mem_chipselect, 0);
      chk("rdw_clken", bus.mem_clken, 1);
      chk("rdw_valid_early", bus.rsp_valid, 0);
      @(negedge clk);
      chk("resp_valid", bus.rsp_valid, 1);
      chk("resp_empty_flag", bus.rsp_empty, 0);
      chk("resp_data", bus.rsp_data, exp_d);
      chk("resp_clken", bus.mem_clken, CLKEN_IDLE);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_data", bus.rsp_data, exp_d);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
      chk_status("hold");
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    if (!was_empty) begin
      void'(m_q.pop_front());
      m_rp = (m_rp + 1) % DEPTH;
    end else begin
      chk("epop_no_access", cs_cnt, c0);
    end
    chk("pop_done_valid", bus.rsp_valid, 0);
    chk("pop_done_ready", bus.cmd_ready, 1);
    chk_status("pop_done");
  endtask

  task automatic do_clear();
    issue(OP_CLEAR, 32'h0);
    model_reset();
    chk("clr_cs", bus.mem_chipselect, 0);
    chk("clr_ready", bus.cmd_ready, 1);
    chk_status("clr");
  endtask

  task automatic do_nop();
    issue(2'b11, $urandom());
    chk("nop_cs", bus.mem_chipselect, 0);
    chk("nop_ready", bus.cmd_ready, 1);
    chk("nop_ovf", bus.ovf_pulse, 0);
    chk_status("nop");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals();

    // Basic push then pop.
    do_push(32'hA5A5_0001);
    do_pop(0);

    // Pop on empty ring.
    do_pop(0);

    // Fill, overflow, wrap.
    do_clear();
    for (int i = 1; i <= 4; i++) do_push(32'(i));
    chk("fill_full", bus.full, 1);
    do_push(32'd5);
    do_pop(0);
    do_push(32'd6);
    repeat (4) do_pop(0);

    // Response back-pressure.
    do_push(32'h0000_0077);
    do_pop(5);

    // Clear discards contents.
    for (int i = 0; i < 3; i++) do_push($urandom());
    do_clear();
    do_pop(0);

    // Reset during RD_WAIT.
    do_push(32'h11);
    do_push(32'h22);
    issue(OP_POP, 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_push(32'h33);
    do_pop(0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       do_push($urandom());
      else if (r < 8)  do_pop($urandom_range(0, 3));
      else if (r == 8) do_clear();
      else             do_nop();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/onchip_ring_master.md
Name: onchip_ring_master

Overview:
- Avalon-MM master that runs a circular word buffer (e.g. snake body segment coordinates) inside the single-port 1024x32 on-chip RAM, driving its s1 slave port directly.
- Game logic issues push (append head word), pop (remove and return tail word) and clear commands over a valid/ready interface; popped words return on a response handshake.
- Sits directly upstream of the on-chip memory and owns its write/read port exclusively.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 32, word width.
- DEPTH, 1024, ring capacity in words; must be <= 2**ADDR_W, any value >= 2.
- BASE, 0, word offset of ring start in RAM; BASE+DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  00 push, 01 pop, 10 clear, 11 reserved (treated as no-op)
- cmd_data  in  DATA_W  push word
- rsp_valid  out  1  pop result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_W  popped word
- rsp_empty  out  1  pop was issued on empty ring; rsp_data=0
- count  out  ADDR_W+1  words held, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- ovf_pulse  out  1  one-cycle pulse: push dropped because full
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  4  to RAM byteenable; always 4'hF when chipselect
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken
- mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE, head=tail=count=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_empty=0, ovf_pulse=0, all mem_* outputs 0 except mem_clken (see Optional Feature). RAM contents are treated as invalid after reset. Reset mid-access aborts it; no partial pointer update.
- All outputs are registered. cmd_ready=1 only in IDLE.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, RESP.
- IDLE, push accepted at cycle T, not full: WR at T+1 with chipselect=1, write=1, address=BASE+head, writedata=cmd_data (latched at T). At the end of T+1, head advances and count increments. IDLE and cmd_ready=1 at T+2.
- IDLE, push accepted while full: no RAM access, ovf_pulse=1 at T+1, state stays IDLE; cmd_ready=1 at T+1.
- IDLE, pop accepted at T, not empty: RD_ISSUE at T+1 (chipselect=1, write=0, address=BASE+tail). RD_WAIT at T+2: chipselect=0; mem_readdata is valid this cycle (one-cycle RAM latency) and is captured. RESP at T+3 with rsp_valid=1, rsp_empty=0.
- In RESP, rsp_valid and rsp_data hold until rsp_ready. In the accept cycle, tail advances and count decrements; the next cycle is IDLE.
- Pop accepted while empty: goes directly to RESP at T+1 with rsp_data=0, rsp_empty=1. No RAM access; pointers unchanged.
- Clear accepted at T: head=tail=count=0 at T+1; state stays IDLE; no RAM access.
- Pointer wrap: head or tail at DEPTH-1 advances to 0. mem_address is always BASE+pointer, ADDR_W bits, no carry beyond.
- Pointers change only from within the FSM, so push and pop can never coincide.
- full and empty are combinational decodes of the registered count.

Optional Feature:
- Macro ONCHIP_RING_CLKGATE_EN.
- Defined: mem_clken=1 only in WR, RD_ISSUE and RD_WAIT, and 0 otherwise (power saving). Reset value is 0.
- Undefined: mem_clken is tied to 1, including during reset.
- Functional timing is identical in both builds.

Decomposition:
- Package onchip_ring_pkg holds:
  - op encodings: OP_PUSH=2'b00, OP_POP=2'b01, OP_CLEAR=2'b10;
  - the FSM state enum;
  - BYTE_ALL=4'hF.
- Sub-module onchip_ring_ptrs holds the head/tail/count registers and the wrap, full and empty logic. Its controls are inc_head, inc_tail and clear.
- The top level keeps the FSM and the Avalon drive.

Test Plan:
- Push 0xA5A5_0001, then pop with rsp_ready=1: write at T+1 to address 0; rsp_valid at pop T+3 with rsp_data=0xA5A5_0001; count goes 1 then 0.
- Pop on empty: rsp_valid at T+1, rsp_empty=1, rsp_data=0; chipselect is never asserted.
- DEPTH=4, BASE=8: push 1..4 (full=1), push 5 gives ovf_pulse and no write; pop returns 1; push 6 writes address 8; pops return 2,3,4,6.
- Pop with rsp_ready held low 5 cycles: rsp_valid and rsp_data stable throughout; cmd_ready=0; count unchanged until the handshake.
- Push 3 words, clear, then pop: rsp_empty=1. Separately, assert reset_n=0 during RD_WAIT: all outputs return to reset values immediately and count=0.
- Build with ONCHIP_RING_CLKGATE_EN: mem_clken high only during the WR/RD_ISSUE/RD_WAIT cycles; pop data matches the ungated build.
